store_sequencer: RTL and testbench

- Multicycle store controller for the datapath's memory-write path.
- For word stores, writes B directly to memory.
- For halfword and byte stores, performs read-modify-write:
  - reads the addressed word into an internal MDR;
  - merges the low B bits into it;
  - writes the merged word back.
- Sits between the register-B/ALU-address stage and the data memory; exposes the captured MDR for reuse by the load path.

---
 rtl/store_sequencer.sv | 128 ++++++++++++
 tb/tb_store_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_sequencer.sv
// Multicycle store controller: word stores write B directly, halfword/byte
// stores read the addressed word into the MDR, merge the low bits of B and write back.
module store_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ss_control,
    input  logic [31:0] addr,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mdr_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] b_reg, b_next;
    logic [1:0]  size_reg, size_next;
    logic [31:0] mdr_reg, mdr_next;
    logic [31:0] wdata_reg, wdata_next;

    logic [3:0]  lane_from_b;
    logic [31:0] merged;

    // Sub-word stores always land in the low lanes; addr[1:0] plays no part.
    always_comb begin
        lane_from_b = 4'b1111;
        case (size_reg)
            SZ_HALF: lane_from_b = 4'b0011;
            SZ_BYTE: lane_from_b = 4'b0001;
            default: lane_from_b = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = lane_from_b[gi] ? b_reg[gi*8 +: 8]
                                                       : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            b_reg     <= '0;
            size_reg  <= '0;
            mdr_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            b_reg     <= b_next;
            size_reg  <= size_next;
            mdr_reg   <= mdr_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        b_next     = b_reg;
        size_next  = size_reg;
        mdr_next   = mdr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next = addr;
                    b_next    = b_in;
                    size_next = ss_control;
                    cnt_next  = '0;
                    case (ss_control)
                        SZ_WORD: begin
                            wdata_next = b_in;
                            state_next = WRITE;
                        end
                        SZ_HALF, SZ_BYTE: begin
                            cnt_next   = CNT_INIT;
                            state_next = READ;
                        end
                        default: state_next = DONE;
                    endcase
                end
            end
            READ: begin
                // The merged word is formed as the read data is captured, so
                // WRITE drives a plain register.
                if (cnt_reg == 3'd0) begin
                    mdr_next   = mem_rdata;
                    wdata_next = merged;
                    state_next = WRITE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign mem_wr    = (state_reg == WRITE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mdr_out   = mdr_reg;

endmodule

// File: tb/tb_store_sequencer.sv
// Bench for store_sequencer: two instances (MEM_LAT=1 and 3) share stimulus,
// each with its own memory; results compared with a word-level model.
module tb_store_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [1:0]  ss_control;
    logic [31:0] addr;
    logic [31:0] b_in;

    logic        busy   [2];
    logic        done   [2];
    logic        mem_wr [2];
    logic [31:0] maddr  [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic [31:0] mdr    [2];

    store_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .ss_control(ss_control),
        .addr(addr), .b_in(b_in), .busy(busy[0]), .done(done[0]),
        .mem_addr(maddr[0]), .mem_wr(mem_wr[0]), .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]), .mdr_out(mdr[0])
    );

    store_sequencer #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .ss_control(ss_control),
        .addr(addr), .b_in(b_in), .busy(busy[1]), .done(done[1]),
        .mem_addr(maddr[1]), .mem_wr(mem_wr[1]), .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]), .mdr_out(mdr[1])
    );

    // Memories are indexed by the low address byte.
    logic [31:0] mem [2][256];
    logic        pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;
    logic [31:0] p0, p1;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[0][pl_a] <= pl_d;
            mem[1][pl_a] <= pl_d;
        end else begin
            if (mem_wr[0]) mem[0][maddr[0][7:0]] <= wdata[0];
            if (mem_wr[1]) mem[1][maddr[1][7:0]] <= wdata[1];
        end
        p0 <= maddr[1];
        p1 <= p0;
    end

    // Latency-3 memory returns garbage until the address has been stable long enough.
    always_comb begin
        rdata[0] = mem[0][maddr[0][7:0]];
        rdata[1] = (p0 == maddr[1] && p1 == maddr[1]) ? mem[1][p1[7:0]] : 32'hBAD0_BAD0;
    end

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] ref_mdr;
    logic [31:0] got;

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre;
        logic [31:0] exp_mem;
        logic [31:0] exp_mdr;
        bit          pulse;
    } vec_t;

    vec_t vecs [7];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] store_result(input logic [31:0] old, input logic [31:0] b,
                                                 input logic [1:0] sz);
        case (sz)
            2'b01:   return b;
            2'b10:   return {old[31:16], b[15:0]};
            2'b11:   return {old[31:8], b[7:0]};
            default: return old;
        endcase
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Called at a negedge with both DUTs idle; returns at the negedge of the
    // first idle cycle so the next call exercises minimum spacing.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b,
                             input bit pulse, output logic [31:0] got_wd);
        int          d_at [2];
        int          wcnt [2];
        int          rcnt [2];
        int          ovl  [2];
        logic [31:0] wa   [2];
        logic [31:0] wd   [2];
        logic [31:0] old, exp_wd;
        int          lat_l, exp_lat, exp_rd, exp_w;
        for (int k = 0; k < 2; k++) begin
            d_at[k] = 0; wcnt[k] = 0; rcnt[k] = 0; ovl[k] = 0;
            wa[k] = '0; wd[k] = '0;
        end
        old    = ref_mem[a[7:0]];
        exp_wd = store_result(old, b, sz);
        start = 1'b1; ss_control = sz; addr = a; b_in = b;
        @(posedge clk);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = pulse;
                addr = $urandom; b_in = $urandom; ss_control = 2'($urandom);
            end else begin
                start = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (d_at[k] == 0) begin
                    if (done[k]) d_at[k] = cyc;
                    if (mem_wr[k]) begin
                        wcnt[k]++; wa[k] = maddr[k]; wd[k] = wdata[k];
                    end
                    if (busy[k] && !mem_wr[k] && !done[k]) rcnt[k]++;
                    if (done[k] && mem_wr[k]) ovl[k]++;
                end
            end
            if (d_at[0] != 0 && d_at[1] != 0) break;
        end
        @(negedge clk);
        start = 1'b0;
        if (sz != 2'b00) ref_mem[a[7:0]] = exp_wd;
        if (sz[1]) ref_mdr = old;
        for (int k = 0; k < 2; k++) begin
            lat_l   = (k == 0) ? 1 : 3;
            exp_lat = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : lat_l + 2;
            exp_rd  = sz[1] ? lat_l : 0;
            exp_w   = (sz == 2'b00) ? 0 : 1;
            check32($sformatf("done_latency_L%0d sz=%0d", lat_l, sz), 32'(d_at[k]), 32'(exp_lat));
            check32($sformatf("write_count_L%0d", lat_l), 32'(wcnt[k]), 32'(exp_w));
            check32($sformatf("read_cycles_L%0d", lat_l), 32'(rcnt[k]), 32'(exp_rd));
            check32($sformatf("done_wr_overlap_L%0d", lat_l), 32'(ovl[k]), 32'd0);
            check32($sformatf("busy_after_L%0d", lat_l), 32'(busy[k]), 32'd0);
            if (exp_w == 1) begin
                check32($sformatf("write_addr_L%0d", lat_l), wa[k], a);
                check32($sformatf("write_data_L%0d", lat_l), wd[k], exp_wd);
            end
            check32($sformatf("mdr_L%0d", lat_l), mdr[k], ref_mdr);
            check32($sformatf("mem_L%0d", lat_l), mem[k][a[7:0]], ref_mem[a[7:0]]);
        end
        got_wd = wd[0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sz     addr       b             pre           exp_mem       exp_mdr       pulse
        vecs[0] = '{2'b01, 32'h40, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1] = '{2'b10, 32'h80, 32'hAAAABBBB, 32'h11223344, 32'h1122BBBB, 32'h11223344, 1'b1};
        vecs[2] = '{2'b11, 32'h10, 32'h000000EE, 32'hCAFEF00D, 32'hCAFEF0EE, 32'hCAFEF00D, 1'b0};
        vecs[3] = '{2'b00, 32'h20, 32'h12345678, 32'h55555555, 32'h55555555, 32'hCAFEF00D, 1'b1};
        vecs[4] = '{2'b01, 32'h41, 32'h01020304, 32'h00000000, 32'h01020304, 32'hCAFEF00D, 1'b1};
        vecs[5] = '{2'b10, 32'h83, 32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{2'b11, 32'hFF, 32'hFFFFFFAB, 32'h00000000, 32'h000000AB, 32'h00000000, 1'b0};

        reset = 1'b0; start = 1'b0; ss_control = 2'b00; addr = '0; b_in = '0;
        pl_en = 1'b0; pl_a = '0; pl_d = '0;
        ref_mdr = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check32($sformatf("reset_busy_%0d", k), 32'(busy[k]), 32'd0);
            check32($sformatf("reset_done_%0d", k), 32'(done[k]), 32'd0);
            check32($sformatf("reset_mem_wr_%0d", k), 32'(mem_wr[k]), 32'd0);
            check32($sformatf("reset_mem_addr_%0d", k), maddr[k], 32'd0);
            check32($sformatf("reset_mem_wdata_%0d", k), wdata[k], 32'd0);
            check32($sformatf("reset_mdr_%0d", k), mdr[k], 32'd0);
        end
        for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            preload(vecs[v].a[7:0], vecs[v].pre);
            run_store(vecs[v].sz, vecs[v].a, vecs[v].b, vecs[v].pulse, got);
            if (vecs[v].sz != 2'b00) check32($sformatf("vec%0d_wdata", v), got, vecs[v].exp_mem);
            check32($sformatf("vec%0d_mem", v), mem[0][vecs[v].a[7:0]], vecs[v].exp_mem);
            check32($sformatf("vec%0d_mdr", v), mdr[1], vecs[v].exp_mdr);
        end

        // Reset dropped while the latency-1 instance is in WRITE.
        preload(8'h30, 32'h0BADF00D);
        start = 1'b1; ss_control = 2'b10; addr = 32'h30; b_in = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check32("rst_pre_write", 32'(mem_wr[0]), 32'd1);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check32($sformatf("rst_busy_%0d", k), 32'(busy[k]), 32'd0);
            check32($sformatf("rst_done_%0d", k), 32'(done[k]), 32'd0);
            check32($sformatf("rst_mem_wr_%0d", k), 32'(mem_wr[k]), 32'd0);
            check32($sformatf("rst_mdr_%0d", k), mdr[k], 32'd0);
            check32($sformatf("rst_mem_addr_%0d", k), maddr[k], 32'd0);
        end
        @(negedge clk);
        check32("rst_mem_intact_0", mem[0][8'h30], 32'h0BADF00D);
        check32("rst_mem_intact_1", mem[1][8'h30], 32'h0BADF00D);
        ref_mdr = '0;
        reset = 1'b1;
        run_store(2'b01, 32'h30, 32'h600DCAFE, 1'b0, got);
        check32("post_rst_word", mem[0][8'h30], 32'h600DCAFE);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  sz;
            logic [31:0] a, b;
            bit          pulse;
            sz    = 2'($urandom);
            a     = $urandom;
            b     = $urandom;
            pulse = 1'($urandom_range(0, 1));
            run_store(sz, a, b, pulse, got);
            $display("txn %0d sz=%0d addr=%h b=%h pulse=%0d wdata=%h", n, sz, a, b, pulse, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
